// File: rtl/tt_pkg.sv
// Shared types and sizing for the truth-table extractor: a 3-input gate has
// 8 rows, and each row contributes one bit to an 8-bit code.
package tt_pkg;
  localparam int N_INPUTS = 3;
  localparam int N_ROWS   = 8;
  localparam int CODE_W   = 8;

  typedef enum logic [1:0] {TT_IDLE, TT_SWEEP, TT_DONE} tt_state_t;
  typedef logic [N_INPUTS-1:0] tt_row_t;
  typedef logic [CODE_W-1:0]   tt_code_t;

  localparam tt_row_t LAST_ROW = tt_row_t'(N_ROWS - 1);
endpackage

// File: rtl/truth_table_extractor_if.sv
// Control/result bundle between the harness and the extractor.
// The compare ports exist only when TT_EXTRACT_COMPARE_EN is defined.
interface truth_table_extractor_if;
  import tt_pkg::*;

  logic     start;
  logic     abort;
  logic     busy;
  logic     done;
  tt_code_t code;
  logic     code_valid;
`ifdef TT_EXTRACT_COMPARE_EN
  tt_code_t expected_code;
  logic     match;

  modport master (output start, abort, expected_code,
                  input  busy, done, code, code_valid, match);
  modport slave  (input  start, abort, expected_code,
                  output busy, done, code, code_valid, match);
`else
  modport master (output start, abort,
                  input  busy, done, code, code_valid);
  modport slave  (input  start, abort,
                  output busy, done, code, code_valid);
`endif
endinterface

// File: rtl/tt_settle_timer.sv
// Per-row hold counter: counts 0..SETTLE_CYCLES while enabled and strobes tc
// on the terminal count, wrapping to 0 on the same edge.
module tt_settle_timer #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       en,
  output logic [7:0] cnt,
  output logic       tc
);
  localparam logic [7:0] TC_VAL = 8'(SETTLE_CYCLES);

  assign tc = en && (cnt == TC_VAL);

  // NOTE: state registers use non-blocking assignments so every flop
  // samples pre-edge values regardless of evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? 8'd0 : cnt + 8'd1;
    end
  end
endmodule

// File: rtl/truth_table_extractor.sv
// Sweeps the 8 input rows of a 3-input gate, samples its output after each
// settle interval and assembles the truth-table code (MSB = row 3'b000).
// Optional compare against a reference code: TT_EXTRACT_COMPARE_EN.
module truth_table_extractor
  import tt_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  truth_table_extractor_if.slave ctrl,
  output tt_row_t                stim,
  input  logic                   dut_out
);
  tt_state_t  state;
  tt_row_t    row;
  logic       accept;
  logic       timer_load;
  logic       timer_en;
  logic       sample;
  logic [7:0] unused_settle_cnt;  // count kept visible for probing only

  // abort outranks start in IDLE
  assign accept     = (state == TT_IDLE) && ctrl.start && !ctrl.abort;
  assign timer_en   = (state == TT_SWEEP);
  assign timer_load = accept || (timer_en && ctrl.abort);

  tt_settle_timer #(
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (timer_load),
    .en    (timer_en),
    .cnt   (unused_settle_cnt),
    .tc    (sample)
  );

`ifdef TT_EXTRACT_COMPARE_EN
  tt_code_t final_code;
  // the row-7 bit lands in code on the same edge that match is registered
  assign final_code = {ctrl.code[CODE_W-1:1], dut_out};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= TT_IDLE;
      row             <= '0;
      stim            <= '0;
      ctrl.busy       <= 1'b0;
      ctrl.done       <= 1'b0;
      ctrl.code       <= '0;
      ctrl.code_valid <= 1'b0;
`ifdef TT_EXTRACT_COMPARE_EN
      ctrl.match      <= 1'b0;
`endif
    end else begin
      ctrl.done <= 1'b0;
      unique case (state)
        TT_IDLE: begin
          if (accept) begin
            state           <= TT_SWEEP;
            row             <= '0;
            stim            <= '0;
            ctrl.busy       <= 1'b1;
            ctrl.code       <= '0;
            ctrl.code_valid <= 1'b0;
`ifdef TT_EXTRACT_COMPARE_EN
            ctrl.match      <= 1'b0;
`endif
          end
        end
        TT_SWEEP: begin
          if (ctrl.abort) begin
            // partial code stays visible but is flagged invalid
            state           <= TT_IDLE;
            row             <= '0;
            stim            <= '0;
            ctrl.busy       <= 1'b0;
            ctrl.code_valid <= 1'b0;
`ifdef TT_EXTRACT_COMPARE_EN
            ctrl.match      <= 1'b0;
`endif
          end else if (sample) begin
            ctrl.code[LAST_ROW - row] <= dut_out;
            if (row == LAST_ROW) begin
              state           <= TT_DONE;
              row             <= '0;
              stim            <= '0;
              ctrl.busy       <= 1'b0;
              ctrl.done       <= 1'b1;
              ctrl.code_valid <= 1'b1;
`ifdef TT_EXTRACT_COMPARE_EN
              ctrl.match      <= (final_code == ctrl.expected_code);
`endif
            end else begin
              row  <= row + 3'd1;
              stim <= row + 3'd1;
            end
          end
        end
        TT_DONE: state <= TT_IDLE;
        default: state <= TT_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_truth_table_extractor.sv
// Self-checking bench: two extractors (settle 4 and settle 0) against gate
// models, with a cycle-count based reference model and directed scenarios.
module tb_truth_table_extractor;
  import tt_pkg::*;

  localparam int S_OF [2] = '{4, 0};

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_r  [2];
  logic       abort_r  [2];
  logic [7:0] gate     [2];
  logic [7:0] exp_code [2];
  logic [2:0] stim_w   [2];
  logic       dut_out_w[2];
  logic       busy_w   [2];
  logic       done_w   [2];
  logic [7:0] code_w   [2];
  logic       valid_w  [2];
  logic       match_w  [2];

  int  n_checks = 0;
  int  n_pass   = 0;
  bit  cmp_en   = 1'b0;

  always #5 clk = ~clk;

  truth_table_extractor_if if_a ();
  truth_table_extractor_if if_b ();

  assign if_a.start = start_r[0];
  assign if_a.abort = abort_r[0];
  assign if_b.start = start_r[1];
  assign if_b.abort = abort_r[1];
  assign busy_w[0]  = if_a.busy;
  assign busy_w[1]  = if_b.busy;
  assign done_w[0]  = if_a.done;
  assign done_w[1]  = if_b.done;
  assign code_w[0]  = if_a.code;
  assign code_w[1]  = if_b.code;
  assign valid_w[0] = if_a.code_valid;
  assign valid_w[1] = if_b.code_valid;
`ifdef TT_EXTRACT_COMPARE_EN
  assign if_a.expected_code = exp_code[0];
  assign if_b.expected_code = exp_code[1];
  assign match_w[0] = if_a.match;
  assign match_w[1] = if_b.match;
`else
  assign match_w[0] = 1'b0;
  assign match_w[1] = 1'b0;
`endif

  // gate under test: out(row) = code[7-row]
  assign dut_out_w[0] = gate[0][3'd7 - stim_w[0]];
  assign dut_out_w[1] = gate[1][3'd7 - stim_w[1]];

  truth_table_extractor #(.SETTLE_CYCLES(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .ctrl(if_a), .stim(stim_w[0]), .dut_out(dut_out_w[0]));
  truth_table_extractor #(.SETTLE_CYCLES(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .ctrl(if_b), .stim(stim_w[1]), .dut_out(dut_out_w[1]));

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0h required %0h at %0t", name, got, exp, $time);
    else
      n_pass++;
  endtask

  // Reference model: k = edges since the accepted start (-1 when idle).
  // A sweep lasts 8*(S+1) edges; after k edges, k/(S+1) rows have been sampled.
  typedef struct packed {
    int       k;
    int       nrows;
    logic [7:0] code;
    bit       valid;
    bit       match;
  } mdl_t;

  mdl_t m [2];

  function automatic logic [7:0] top_mask(input int n);
    logic [7:0] ff = 8'hFF;
    return ~(ff >> n);
  endfunction

  function automatic bit m_busy(input mdl_t x, input int s);
    return (x.k >= 0) && (x.k < 8 * (s + 1));
  endfunction

  function automatic bit m_done(input mdl_t x, input int s);
    return x.k == 8 * (s + 1);
  endfunction

  function automatic logic [2:0] m_stim(input mdl_t x, input int s);
    return m_busy(x, s) ? 3'(x.k / (s + 1)) : 3'd0;
  endfunction

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r.k = -1; r.nrows = 0; r.code = 8'h00; r.valid = 1'b0; r.match = 1'b0;
    return r;
  endfunction

  function automatic mdl_t mdl_step(input mdl_t x, input bit st, input bit ab,
                                    input int s, input logic [7:0] g, input logic [7:0] e);
    mdl_t n = x;
    int len = 8 * (s + 1);
    if (x.k < 0) begin
      if (st && !ab) begin
        n.k = 0; n.nrows = 0; n.code = 8'h00; n.valid = 1'b0; n.match = 1'b0;
      end
    end else if (x.k == len) begin
      n.k = -1;
    end else if (ab) begin
      n.k = -1; n.valid = 1'b0; n.match = 1'b0;
    end else begin
      n.k     = x.k + 1;
      n.nrows = n.k / (s + 1);
      n.code  = g & top_mask(n.nrows);
      if (n.k == len) begin
        n.valid = 1'b1;
        n.match = (g == e);
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) m[i] <= mdl_reset();
    end else begin
      for (int i = 0; i < 2; i++)
        m[i] <= mdl_step(m[i], start_r[i], abort_r[i], S_OF[i], gate[i], exp_code[i]);
    end
  end

  // compare process: every falling edge, both extractors against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("stim[%0d]", i),  {29'd0, stim_w[i]}, {29'd0, m_stim(m[i], S_OF[i])});
        check($sformatf("busy[%0d]", i),  {31'd0, busy_w[i]}, {31'd0, m_busy(m[i], S_OF[i])});
        check($sformatf("done[%0d]", i),  {31'd0, done_w[i]}, {31'd0, m_done(m[i], S_OF[i])});
        check($sformatf("code[%0d]", i),  {24'd0, code_w[i]}, {24'd0, m[i].code});
        check($sformatf("valid[%0d]", i), {31'd0, valid_w[i]}, {31'd0, m[i].valid});
`ifdef TT_EXTRACT_COMPARE_EN
        check($sformatf("match[%0d]", i), {31'd0, match_w[i]}, {31'd0, m[i].match});
`endif
      end
    end
  end

  // pulse start so it is sampled at edge E0; returns just after E0's falling edge
  task automatic pulse_start(input int idx);
    @(negedge clk); start_r[idx] = 1'b1;
    @(posedge clk);
    @(negedge clk); start_r[idx] = 1'b0;
  endtask

  task automatic run_sweep(input int idx, input logic [7:0] g, input int exp_lat, input string tag);
    int lat = 0;
    gate[idx] = g;
    pulse_start(idx);
    for (int n = 1; n <= 400 && lat == 0; n++) begin
      @(posedge clk); #1;
      if (done_w[idx] === 1'b1) lat = n;
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_code"}, {24'd0, code_w[idx]}, {24'd0, g});
    check({tag, "_valid"}, {31'd0, valid_w[idx]}, 32'd1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int dones;
    int done_at;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start_r[i] = 1'b0; abort_r[i] = 1'b0; exp_code[i] = 8'h00;
    end
    gate[0] = 8'hDA;
    gate[1] = 8'h96;
    repeat (2) @(negedge clk);

    check("reset_stim",  {29'd0, stim_w[0]}, 32'd0);
    check("reset_busy",  {31'd0, busy_w[0]}, 32'd0);
    check("reset_done",  {31'd0, done_w[0]}, 32'd0);
    check("reset_code",  {24'd0, code_w[0]}, 32'h00);
    check("reset_valid", {31'd0, valid_w[0]}, 32'd0);
    rst_n  = 1'b1;
    cmp_en = 1'b1;
    @(negedge clk);

    // basic sweep, S=4, gate DA
    run_sweep(0, 8'hDA, 40, "da_s4");

    // code ordering corners
    run_sweep(0, 8'h00, 40, "c00");
    run_sweep(0, 8'hFF, 40, "cff");
    run_sweep(0, 8'h01, 40, "c01");
    run_sweep(0, 8'h80, 40, "c80");

    // zero settle interval
    run_sweep(1, 8'h96, 8, "c96_s0");

    // abort sampled at edge E0+12: rows 0,1 done -> DA & C0
    gate[0] = 8'hDA;
    pulse_start(0);
    repeat (11) @(posedge clk);
    @(negedge clk); abort_r[0] = 1'b1;
    @(posedge clk); #1;
    check("abort_busy",  {31'd0, busy_w[0]}, 32'd0);
    check("abort_stim",  {29'd0, stim_w[0]}, 32'd0);
    check("abort_valid", {31'd0, valid_w[0]}, 32'd0);
    check("abort_code",  {24'd0, code_w[0]}, 32'hC0);
    @(negedge clk); abort_r[0] = 1'b0;
    dones = 0;
    for (int n = 0; n < 50; n++) begin
      @(posedge clk); #1;
      if (done_w[0] === 1'b1) dones++;
    end
    check("abort_no_done", dones, 0);
    run_sweep(0, 8'hDA, 40, "after_abort");

    // abort and start together in IDLE: nothing starts
    @(negedge clk); start_r[0] = 1'b1; abort_r[0] = 1'b1;
    @(posedge clk); #1;
    check("abort_start_idle_busy", {31'd0, busy_w[0]}, 32'd0);
    @(negedge clk); start_r[0] = 1'b0; abort_r[0] = 1'b0;

    // start at E0+7 and during DONE are ignored
    pulse_start(0);
    dones = 0; done_at = 0;
    for (int n = 1; n <= 60; n++) begin
      if (n == 7 || n == 41) begin
        @(negedge clk); start_r[0] = 1'b1;
      end
      @(posedge clk); #1;
      start_r[0] = 1'b0;
      if (n == 5) check("stim_row1_at_e5", {29'd0, stim_w[0]}, 32'd1);
      if (n == 7) check("stim_at_e7", {29'd0, stim_w[0]}, 32'd1);
      if (done_w[0] === 1'b1) begin dones++; done_at = n; end
    end
    check("restart_single_done", dones, 1);
    check("restart_done_at", done_at, 40);

    // asynchronous reset mid-sweep at E0+20
    pulse_start(0);
    repeat (20) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_stim",  {29'd0, stim_w[0]}, 32'd0);
    check("midrst_busy",  {31'd0, busy_w[0]}, 32'd0);
    check("midrst_code",  {24'd0, code_w[0]}, 32'h00);
    check("midrst_valid", {31'd0, valid_w[0]}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

`ifdef TT_EXTRACT_COMPARE_EN
    exp_code[0] = 8'hDA;
    run_sweep(0, 8'hDA, 40, "cmp_eq");
    check("match_eq", {31'd0, match_w[0]}, 32'd1);
    exp_code[0] = 8'hDB;
    run_sweep(0, 8'hDA, 40, "cmp_ne");
    check("match_ne", {31'd0, match_w[0]}, 32'd0);
    exp_code[0] = 8'hDA;
    run_sweep(0, 8'hDA, 40, "cmp_eq2");
    pulse_start(0);
    check("match_cleared_on_start", {31'd0, match_w[0]}, 32'd0);
    @(negedge clk); abort_r[0] = 1'b1;
    @(negedge clk); abort_r[0] = 1'b0;
    @(negedge clk);
`endif

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
